seg_scan_controller: RTL

SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

---
 rtl/seg_scan_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// Multiplexed 7-seg scan controller: seg/digit_en are combinational from index+display regs; loads commit tear-free on frame_tick.
// load_ready is low while a word is pending; define SEG_LEADING_ZERO_BLANK_EN to blank leading-zero digits.
module seg_scan_controller #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*DIGITS-1:0] load_data,
  input  logic                dec_mode,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   digit_en,
  output logic                frame_tick
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow, disp;
  logic                slot_tick, shadow_we, commit;
  logic [3:0]          nib;
  logic [6:0]          hex_seg;
  logic                dec_blank;

  assign slot_tick  = (cnt == CNT_LAST);
  assign frame_tick = slot_tick && (idx == IDX_LAST);
  assign digit_en   = DIGITS'(1) << idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_tick ? '0 : cnt + 1'b1;
      if (slot_tick)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_valid) state_nxt = PENDING;
      PENDING: if (frame_tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A word accepted on a frame_tick is still in IDLE, so it waits for the next tick.
  always_comb begin
    load_ready = (state == IDLE);
    shadow_we  = (state == IDLE) && load_valid;
    commit     = (state == PENDING) && frame_tick;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      disp   <= '0;
    end else begin
      if (shadow_we) shadow <= load_data;
      if (commit)    disp   <= shadow;
    end
  end

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < DIGITS; i++)
      if (idx == IDX_W'(i)) nib = disp[4*i +: 4];
  end

  always_comb begin
    case (nib)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      default: hex_seg = 7'h71;
    endcase
  end

  assign dec_blank = dec_mode && (nib > 4'd9);

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic lz_blank, upper_zero;

  // Walk down from the top digit; digit 0 is never considered.
  always_comb begin
    lz_blank   = 1'b0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (disp[4*i +: 4] == 4'h0);
      if ((idx == IDX_W'(i)) && upper_zero) lz_blank = 1'b1;
    end
  end

  assign seg = (dec_blank || lz_blank) ? 7'h00 : hex_seg;
`else
  assign seg = dec_blank ? 7'h00 : hex_seg;
`endif

endmodule
